// File: rtl/serial_inc_pkg.sv
// Shared types for the serial incrementer arbiter: FSM states, owner id and
// the round-robin pick used when both requesters are valid.
package serial_inc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    RESP  = 2'b10
  } state_t;

  typedef logic owner_t;

  // prio names the requester favoured on a tie; a lone requester always wins.
  function automatic owner_t rr_pick(input logic [1:0] valid, input owner_t prio);
    if (valid == 2'b11) begin
      return prio;
    end else if (valid[1]) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/serial_add1_bit.sv
// One-bit serial adder for +1: carry starts at 1 on start and ripples
// forward one operand bit per clock.
module serial_add1_bit
  import serial_inc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic in_bit,
  output logic out_bit,
  output logic carry_out
);

  logic carry;

  always_ff @(posedge clk) begin
    if (reset || start) begin
      carry <= 1'b1;
    end else begin
      carry <= carry_out;
    end
  end

  assign out_bit   = in_bit ^ carry;
  assign carry_out = in_bit & carry;

endmodule

// File: rtl/serial_inc_arbiter.sv
// Two requesters share one bit-serial +1 unit: round-robin grant, LSB-first
// shift for WIDTH cycles, then the response is held until its owner takes it.
module serial_inc_arbiter
  import serial_inc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  output logic [1:0]       req_ready,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  owner_t           owner;
  owner_t           grant_id;
  owner_t           prio;
  logic             accept;
  logic             last_bit;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] op_sr;
  logic [WIDTH-1:0] res_sr;
  logic             ovf_q;
  logic             sum_bit;
  logic             carry_out;

  serial_add1_bit u_add1 (
    .clk       (clk),
    .reset     (reset),
    .start     (accept),
    .in_bit    (op_sr[0]),
    .out_bit   (sum_bit),
    .carry_out (carry_out)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    req_ready  = 2'b00;
    rsp_valid  = 2'b00;
    grant_id   = rr_pick(req_valid, prio);
    last_bit   = (bit_cnt == LAST_BIT);
    case (state)
      IDLE: begin
        if (|req_valid) begin
          accept     = 1'b1;
          req_ready  = grant_id ? 2'b10 : 2'b01;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid = owner ? 2'b10 : 2'b01;
        if (rsp_ready[owner]) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Result bits enter at the MSB and walk down, so after WIDTH shifts the
  // first (least significant) sum bit sits in bit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= 1'b0;
      prio    <= 1'b0;
      bit_cnt <= '0;
      op_sr   <= '0;
      res_sr  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        owner   <= grant_id;
        prio    <= ~grant_id;
        bit_cnt <= '0;
        op_sr   <= grant_id ? req_data1 : req_data0;
      end
      if (state == SHIFT) begin
        op_sr   <= op_sr >> 1;
        res_sr  <= {sum_bit, res_sr[WIDTH-1:1]};
        bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
        if (last_bit) begin
          ovf_q <= carry_out;
        end
      end
    end
  end

  assign rsp_data = res_sr;
  assign rsp_ovf  = ovf_q;

endmodule

// File: tb/tb_serial_inc_arbiter.sv
// Self-checking bench for serial_inc_arbiter: directed vector table, hand
// sequences for stall/abort/WIDTH=8, and randomized transactions vs a model.
module tb_serial_inc_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid;
  logic [W-1:0] req_data0;
  logic [W-1:0] req_data1;
  logic [1:0]   req_ready;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_ovf;

  logic [1:0]   req_valid8;
  logic [7:0]   req_data0_8;
  logic [7:0]   req_data1_8;
  logic [1:0]   req_ready8;
  logic [1:0]   rsp_valid8;
  logic [1:0]   rsp_ready8;
  logic [7:0]   rsp_data8;
  logic         rsp_ovf8;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic last_granted;

  serial_inc_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_ovf   (rsp_ovf)
  );

  serial_inc_arbiter #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid8),
    .req_data0 (req_data0_8),
    .req_data1 (req_data1_8),
    .req_ready (req_ready8),
    .rsp_valid (rsp_valid8),
    .rsp_ready (rsp_ready8),
    .rsp_data  (rsp_data8),
    .rsp_ovf   (rsp_ovf8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   valid;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    int           stall;
    logic [1:0]   exp_ready;
    logic [1:0]   exp_valid;
    logic [W-1:0] exp_data;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic applyStimulus(input logic [1:0] v, input logic [W-1:0] d0,
                               input logic [W-1:0] d1, input logic [1:0] rr);
    req_valid = v;
    req_data0 = d0;
    req_data1 = d1;
    rsp_ready = rr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full transaction from the IDLE cycle through response release.
  // Operand inputs are scrambled after acceptance and both rsp_ready bits are
  // high during the shift; neither may disturb the result.
  task automatic runTxn(input string tag, input logic [1:0] valid,
                        input logic [W-1:0] d0, input logic [W-1:0] d1, input int stall,
                        input logic [1:0] exp_ready, input logic [1:0] exp_valid,
                        input logic [W-1:0] exp_data, input logic exp_ovf);
    @(negedge clk);
    applyStimulus(valid, d0, d1, 2'b00);
    #1;
    checkOutput({tag, ".grant"}, 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      applyStimulus(valid, W'($urandom), W'($urandom), 2'b11);
      #1;
      checkOutput({tag, ".busy"}, 32'({req_ready, rsp_valid}), 32'(0));
      @(posedge clk);
    end
    for (int s = 0; s <= stall; s++) begin
      @(negedge clk);
      applyStimulus(valid, W'($urandom), W'($urandom), (s == stall) ? 2'b11 : ~exp_valid);
      #1;
      checkOutput({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(exp_valid));
      checkOutput({tag, ".rsp_data"}, 32'(rsp_data), 32'(exp_data));
      checkOutput({tag, ".rsp_ovf"}, 32'(rsp_ovf), 32'(exp_ovf));
      checkOutput({tag, ".no_grant"}, 32'(req_ready), 32'(0));
      @(posedge clk);
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(2'b00, '0, '0, 2'b00);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    last_granted = 1'b1;
  endtask

  initial begin
    logic [1:0]   v;
    logic [W-1:0] a0, a1, op;
    logic         g;
    int           st;

    vecs[0] = '{2'b01, 4'h5, 4'h0, 0, 2'b01, 2'b01, 4'h6, 1'b0};
    vecs[1] = '{2'b10, 4'h0, 4'hF, 0, 2'b10, 2'b10, 4'h0, 1'b1};
    vecs[2] = '{2'b11, 4'h3, 4'h7, 0, 2'b01, 2'b01, 4'h4, 1'b0};
    vecs[3] = '{2'b11, 4'h3, 4'h7, 0, 2'b10, 2'b10, 4'h8, 1'b0};
    vecs[4] = '{2'b11, 4'h3, 4'h7, 0, 2'b01, 2'b01, 4'h4, 1'b0};
    vecs[5] = '{2'b11, 4'h3, 4'h7, 3, 2'b10, 2'b10, 4'h8, 1'b0};
    vecs[6] = '{2'b01, 4'hF, 4'h2, 0, 2'b01, 2'b01, 4'h0, 1'b1};
    vecs[7] = '{2'b10, 4'h9, 4'h0, 0, 2'b10, 2'b10, 4'h1, 1'b0};
    vecs[8] = '{2'b11, 4'hE, 4'hC, 3, 2'b01, 2'b01, 4'hF, 1'b0};

    reset = 1'b1;
    applyStimulus(2'b00, '0, '0, 2'b00);
    req_valid8 = 2'b00; req_data0_8 = '0; req_data1_8 = '0; rsp_ready8 = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.outputs", 32'({req_ready, rsp_valid, rsp_data, rsp_ovf}), 32'(0));
    checkOutput("reset.outputs8", 32'({req_ready8, rsp_valid8, rsp_data8, rsp_ovf8}), 32'(0));
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      runTxn($sformatf("vec%0d", i), vecs[i].valid, vecs[i].d0, vecs[i].d1, vecs[i].stall,
             vecs[i].exp_ready, vecs[i].exp_valid, vecs[i].exp_data, vecs[i].exp_ovf);
    end

    // Leave ovf=1 and requester 0 last served, then abort a second req0
    // operation two bits in; afterwards requester 0 must again win a tie.
    runTxn("pre_abort", 2'b01, 4'hF, 4'h0, 0, 2'b01, 2'b01, 4'h0, 1'b1);
    @(negedge clk);
    applyStimulus(2'b01, 4'hA, 4'h0, 2'b00);
    #1;
    checkOutput("abort.grant", 32'(req_ready), 32'(2'b01));
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      applyStimulus(2'b01, 4'hA, 4'h0, 2'b11);
      @(posedge clk);
    end
    pulseReset();
    #1;
    checkOutput("abort.outputs", 32'({req_ready, rsp_valid, rsp_data, rsp_ovf}), 32'(0));
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      applyStimulus(2'b00, '0, '0, 2'b11);
      #1;
      checkOutput("abort.no_rsp", 32'({req_ready, rsp_valid}), 32'(0));
    end
    runTxn("post_abort", 2'b11, 4'h3, 4'h7, 0, 2'b01, 2'b01, 4'h4, 1'b0);

    // Randomized transactions against a spec-level model: result is op+1
    // modulo 2^W, overflow when op is all ones, ties go to whoever was not
    // granted last.
    pulseReset();
    for (int t = 0; t < 40; t++) begin
      v  = 2'($urandom_range(1, 3));
      a0 = W'($urandom);
      a1 = W'($urandom);
      st = $urandom_range(0, 3);
      g  = (v == 2'b11) ? ~last_granted : v[1];
      op = g ? a1 : a0;
      runTxn($sformatf("rand%0d", t), v, a0, a1, st,
             g ? 2'b10 : 2'b01, g ? 2'b10 : 2'b01,
             W'((32'(op) + 1) % (1 << W)), op == {W{1'b1}});
      last_granted = g;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        applyStimulus(2'b00, W'($urandom), W'($urandom), 2'($urandom));
        #1;
        checkOutput("rand.idle", 32'({req_ready, rsp_valid}), 32'(0));
        @(posedge clk);
      end
    end

    // WIDTH=8: 8'h7F -> 8'h80 with no overflow, valid WIDTH+1 cycles later.
    @(negedge clk);
    applyStimulus(2'b00, '0, '0, 2'b00);
    req_valid8 = 2'b01; req_data0_8 = 8'h7F; req_data1_8 = 8'h00; rsp_ready8 = 2'b11;
    #1;
    checkOutput("w8.grant", 32'(req_ready8), 32'(2'b01));
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_valid8 = 2'b00;
      req_data0_8 = 8'($urandom);
      #1;
      checkOutput("w8.busy", 32'({req_ready8, rsp_valid8}), 32'(0));
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    checkOutput("w8.rsp_valid", 32'(rsp_valid8), 32'(2'b01));
    checkOutput("w8.rsp_data", 32'(rsp_data8), 32'(8'h80));
    checkOutput("w8.rsp_ovf", 32'(rsp_ovf8), 32'(0));
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("w8.released", 32'(rsp_valid8), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/serial_inc_arbiter.md
SERIAL_INC_ARBITER -- requirements
Module: serial_inc_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/result width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  2  per-requester operand valid; index 0 and 1.
REQ-005 SHALL have port req_data0  input  WIDTH  operand of requester 0.
REQ-006 SHALL have port req_data1  input  WIDTH  operand of requester 1.
REQ-007 SHALL have port req_ready  output  2  one-hot-or-zero accept strobe per requester.
REQ-008 SHALL have port rsp_valid  output  2  one-hot-or-zero result valid, indexed by owning requester.
REQ-009 SHALL have port rsp_ready  input  2  per-requester result acceptance.
REQ-010 SHALL have port rsp_data  output  WIDTH  result, operand+1 modulo 2^WIDTH.
REQ-011 SHALL have port rsp_ovf  output  1  high when operand was all ones (result wrapped to 0).

Function
REQ-012 SHALL share one bit-serial incrementer between two requesters; one operation in flight at a time.
REQ-013 SHALL implement FSM states IDLE, SHIFT, RESP.
REQ-014 IDLE: if any req_valid, SHALL grant one requester by round-robin, assert its req_ready combinationally that cycle, latch its operand and owner id, go to SHIFT; else stay IDLE.
REQ-015 Round-robin SHALL favour the requester not granted last when both valid; after reset requester 0 has priority.
REQ-016 req_ready SHALL be low in SHIFT and RESP.
REQ-017 SHIFT SHALL present operand bits LSB first, one per cycle, for exactly WIDTH cycles, with serial carry initialised to 1 at bit 0.
REQ-018 Each serial output bit SHALL equal operand bit XOR carry; next carry SHALL be operand bit AND carry.
REQ-019 Output bits SHALL be collected LSB first into a WIDTH-bit result register; final carry-out SHALL be stored as rsp_ovf.
REQ-020 After the WIDTH-th bit SHALL go to RESP; rsp_valid[owner] rises WIDTH+1 cycles after the accepting edge.
REQ-021 RESP: rsp_data, rsp_ovf, rsp_valid SHALL hold stable until rsp_ready[owner] high; on that edge go to IDLE.
REQ-022 rsp_ready of the non-owner SHALL be ignored.
REQ-023 A new request SHALL NOT be accepted in the cycle the response completes; earliest re-accept is the following cycle (IDLE).
REQ-024 Changes on req_data after acceptance SHALL NOT affect the result.
REQ-025 Unreachable FSM encodings SHALL return to IDLE.

Reset
REQ-026 On reset: state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_ovf=0, carry=1, bit counter=0, priority to requester 0.
REQ-027 Reset asserted in SHIFT or RESP SHALL abort the operation with no response produced.

Structure
REQ-028 State enum and owner-id type SHALL live in shared package serial_inc_pkg.
REQ-029 Serial bit add-with-carry SHALL be sub-module serial_add1_bit (inputs clk, reset, start, in_bit; output out_bit, carry_out); arbiter, counter, shift registers stay in top.
REQ-030 Bit counter SHALL be $clog2(WIDTH+1) bits wide.

Verification
REQ-031 Req0 only, data 4'h5, rsp_ready=1 -> req_ready=2'b01 at cycle 0; rsp_valid=2'b01, rsp_data=4'h6, rsp_ovf=0 at cycle 5.
REQ-032 Req1 data 4'hF -> rsp_data=4'h0, rsp_ovf=1, rsp_valid=2'b10.
REQ-033 Both valid continuously, data0=4'h3, data1=4'h7 -> grants alternate 0,1,0,1; results 4'h4 and 4'h8 to correct owner.
REQ-034 Owner rsp_ready held low 3 cycles, non-owner rsp_ready high -> rsp_valid/rsp_data stable 3 cycles, no new grant until release.
REQ-035 Reset pulsed mid-SHIFT (after 2 bits) -> next cycle all outputs 0, state IDLE, next grant to requester 0 even if requester 1 was last served.
REQ-036 WIDTH=8, data 8'h7F -> rsp_data=8'h80 at cycle 9, rsp_ovf=0.
